// File: rtl/fp_cmd_decoder.sv
// ---------------------------------------------------------------------------
// fp_cmd_decoder
//
// Purpose:
//   This block turns the byte stream from the front-panel SPI receiver into
//   register write strobes for the front-panel register bank.
//   - RXFLAG and SS are asynchronous to clk_i, so both are synchronised first.
//   - Each completed byte is captured on the rising edge of the synchronised
//     RXFLAG.
//   - Command frames are then parsed by a small FSM.
//
// Ports:
//   clk_i        system clock. It must run at 4x the SCLK frequency or faster.
//   rst_n_i      asynchronous active-low reset.
//   rxdata_i     received byte. It is stable while rxflag_i is high.
//   rxflag_i     byte-complete flag from the SPI receiver (SCLK domain).
//   ss_i         SPI slave select, active-low, raw pin.
//   wr_en_o      single-cycle write strobe.
//   wr_addr_o    write address. It holds until the next write.
//   wr_data_o    write data. It holds until the next write.
//   frame_err_o  single-cycle frame error pulse.
//   busy_o       high while the FSM is not in IDLE.
//
// Frame format:
//   The first byte after SS falls is CMD.
//   - CMD[7:4] is the opcode: 0 = NOP, 1 = single write, 2 = burst write.
//   - CMD[ADDR_W-1:0] is the register address.
//
// Optional feature (macro FP_CMD_CHECKSUM_EN):
//   Single-write frames carry a third byte, CSUM = CMD ^ DATA.
//   The write only issues when the checksum matches.
// ---------------------------------------------------------------------------
module fp_cmd_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        rxdata_i,
  input  logic              rxflag_i,
  input  logic              ss_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_BURST   = 3'd2,
    ST_DISCARD = 3'd3
`ifdef FP_CMD_CHECKSUM_EN
    ,
    ST_CSUM    = 3'd4
`endif
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_BURST = 4'h2;

  // -------------------------------------------------------------------------
  // Synchronisers and byte capture
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] flag_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   flag_prev_q;
  logic                   ss_prev_q;
  logic                   byte_stb_q;
  logic                   ss_rise_q;
  logic [7:0]             rxbyte_q;

  logic flag_s;
  logic ss_s;
  logic flag_rise;

  assign flag_s    = flag_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign flag_rise = flag_s & ~flag_prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flag_sync_q <= '0;
      ss_sync_q   <= '1;
      flag_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      byte_stb_q  <= 1'b0;
      ss_rise_q   <= 1'b0;
      rxbyte_q    <= 8'h00;
    end else begin
      flag_sync_q <= {flag_sync_q[SYNC_STAGES-2:0], rxflag_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      flag_prev_q <= flag_s;
      ss_prev_q   <= ss_s;
      byte_stb_q  <= flag_rise;
      ss_rise_q   <= ss_s & ~ss_prev_q;
      // RXDATA is still held by the receiver because RXFLAG is high at this point.
      if (flag_rise) begin
        rxbyte_q <= rxdata_i;
      end
    end
  end

  // ss_prev_q is the synchronised SS level aligned with byte_stb_q.
  // A byte that coincides with the SS rise is still accepted; it belongs to the closing frame.
  logic byte_ok;
  assign byte_ok = byte_stb_q & (~ss_prev_q | ss_rise_q);

  logic [3:0] opcode;
  assign opcode = rxbyte_q[7:4];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_err_q, frame_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
`ifdef FP_CMD_CHECKSUM_EN
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        data_q, data_d;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
`ifdef FP_CMD_CHECKSUM_EN
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef FP_CMD_CHECKSUM_EN
      cmd_q       <= cmd_d;
      data_q      <= data_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_ok) begin
          case (opcode)
            OP_NOP:   state_d = ST_DISCARD;
            OP_WRITE: state_d = ST_DATA;
            OP_BURST: state_d = ST_BURST;
            default:  state_d = ST_DISCARD;
          endcase
        end
      end
      ST_DATA: begin
        if (byte_ok) begin
`ifdef FP_CMD_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DISCARD;
`endif
        end
      end
`ifdef FP_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_ok) begin
          state_d = ST_DISCARD;
        end
      end
`endif
      default: state_d = state_q;
    endcase
    // The end of the frame overrides everything else. Any byte arriving
    // with it has already been handled in the output logic.
    if (ss_rise_q) begin
      state_d = ST_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    addr_d      = addr_q;
`ifdef FP_CMD_CHECKSUM_EN
    cmd_d       = cmd_q;
    data_d      = data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (byte_ok) begin
`ifdef FP_CMD_CHECKSUM_EN
          cmd_d = rxbyte_q;
`endif
          if (opcode == OP_WRITE || opcode == OP_BURST) begin
            addr_d = rxbyte_q[ADDR_W-1:0];
          end
          if (opcode == OP_WRITE) begin
            // A single write that closes on its CMD byte is truncated.
            frame_err_d = ss_rise_q;
          end else if (opcode != OP_NOP && opcode != OP_BURST) begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (byte_ok) begin
`ifdef FP_CMD_CHECKSUM_EN
          data_d      = rxbyte_q;
          frame_err_d = ss_rise_q;
`else
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rxbyte_q;
`endif
        end else if (ss_rise_q) begin
          frame_err_d = 1'b1;
        end
      end
`ifdef FP_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_ok) begin
          if (rxbyte_q == (cmd_q ^ data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (ss_rise_q) begin
          frame_err_d = 1'b1;
        end
      end
`endif
      ST_BURST: begin
        if (byte_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rxbyte_q;
          addr_d    = addr_q + ADDR_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_fp_cmd_decoder
//
// Self-checking bench for fp_cmd_decoder.
// - The stimulus is directed frames followed by randomised frames.
// - A frame-level reference model derives the expected writes and error
//   pulses from the byte list of each frame.
// - Define FP_CMD_CHECKSUM_EN for both the bench and the RTL to exercise
//   the checksum build.
// ---------------------------------------------------------------------------
module tb_fp_cmd_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rxdata = 8'h00;
  logic              rxflag = 1'b0;
  logic              ss = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_err;
  logic              busy;

  fp_cmd_decoder #(.SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rxdata_i    (rxdata),
    .rxflag_i    (rxflag),
    .ss_i        (ss),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .frame_err_o (frame_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // ---------------- monitor (sole writer of these) ----------------
  logic [11:0] obs_q[$];
  int          err_seen = 0;
  int          dbl_cnt  = 0;
  logic        prev_wr  = 1'b0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (wr_en) obs_q.push_back({wr_addr, wr_data});
    if (frame_err) err_seen = err_seen + 1;
    if ((wr_en && prev_wr) || (frame_err && prev_err)) dbl_cnt = dbl_cnt + 1;
    prev_wr  = wr_en;
    prev_err = frame_err;
  end

  // ---------------- reference model ----------------
  logic [7:0]  frame_q[$];
  logic [11:0] exp_q[$];
  int          exp_err;
  logic [11:0] held;   // last written {addr,data}, expected on the hold outputs

  task automatic model_frame();
    int op;
    int a;
    exp_q.delete();
    exp_err = 0;
    if (frame_q.size() == 0) return;
    op = int'(frame_q[0]) / 16;
    a  = int'(frame_q[0]) % (1 << ADDR_W);
    if (op == 0) begin
      // NOP: no effect
    end else if (op == 1) begin
`ifdef FP_CMD_CHECKSUM_EN
      if (frame_q.size() >= 3) begin
        if (frame_q[2] == (frame_q[0] ^ frame_q[1])) exp_q.push_back({4'(a), frame_q[1]});
        else exp_err = 1;
      end else begin
        exp_err = 1;
      end
`else
      if (frame_q.size() >= 2) exp_q.push_back({4'(a), frame_q[1]});
      else exp_err = 1;
`endif
    end else if (op == 2) begin
      for (int i = 1; i < frame_q.size(); i++)
        exp_q.push_back({4'((a + i - 1) % (1 << ADDR_W)), frame_q[i]});
    end else begin
      exp_err = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit lat);
    @(negedge clk);
    rxdata = b;
    rxflag = 1'b1;
    if (lat) begin
      @(posedge clk);                 // edge n: RXFLAG first sampled high
      repeat (SYNC_STAGES) @(posedge clk);
      @(negedge clk); check("lat_early", 32'(wr_en), 32'd0);
      @(posedge clk);                 // edge n+SYNC_STAGES+1
      @(negedge clk); check("lat_hit", 32'(wr_en), 32'd1);
      @(posedge clk);
      @(negedge clk); check("lat_drop", 32'(wr_en), 32'd0);
    end else begin
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    rxflag = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_frame(input string tag, input bit lat_last);
    int obs_base;
    int err_base;
    int n;
    model_frame();
    obs_base = obs_q.size();
    err_base = err_seen;
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], lat_last && (i == frame_q.size() - 1));
      if (i == 0) begin
        @(negedge clk); check({tag, "_busy_mid"}, 32'(busy), 32'd1);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    ss = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n = obs_q.size() - obs_base;
    check({tag, "_nwr"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check({tag, "_wr"}, 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
    check({tag, "_err"}, 32'(err_seen - err_base), 32'(exp_err));
    if (exp_q.size() > 0) held = exp_q[exp_q.size() - 1];
    check({tag, "_hold"}, 32'({wr_addr, wr_data}), 32'(held));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    $display("frame %s: %0d bytes, %0d writes, %0d errors", tag, frame_q.size(), n, err_seen - err_base);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    held = 12'h000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1+2: single write with latency check on the completing byte
`ifdef FP_CMD_CHECKSUM_EN
    frame_q = '{8'h13, 8'hA5, 8'hB6};
`else
    frame_q = '{8'h13, 8'hA5};
`endif
    run_frame("single", 1'b1);
    check("single_addr", 32'(wr_addr), 32'd3);
    check("single_data", 32'(wr_data), 32'hA5);

    // 3: burst wrapping through the top address
    frame_q = '{8'h2E, 8'h11, 8'h22, 8'h33};
    run_frame("burst", 1'b0);
    check("burst_addr", 32'(wr_addr), 32'd0);
    check("burst_data", 32'(wr_data), 32'h33);

    // 4: bad opcode then ignored byte; truncated single write
    frame_q = '{8'h53, 8'h44};
    run_frame("badop", 1'b0);
    frame_q = '{8'h17};
    run_frame("trunc", 1'b0);

    // 5: asynchronous reset mid-burst
    frame_q = '{8'h20, 8'h01};
    begin
      int base;
      base = obs_q.size();
      @(negedge clk); ss = 1'b0;
      repeat (4) @(posedge clk);
      send_byte(8'h20, 1'b0);
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      check("rst_pre_nwr", 32'(obs_q.size() - base), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wr_en", 32'(wr_en), 32'd0);
      check("arst_ferr", 32'(frame_err), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_addr", 32'(wr_addr), 32'd0);
      check("arst_data", 32'(wr_data), 32'd0);
      ss = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      held = 12'h000;
      repeat (3) @(posedge clk);
    end
`ifdef FP_CMD_CHECKSUM_EN
    frame_q = '{8'h14, 8'h99, 8'h8D};
`else
    frame_q = '{8'h14, 8'h99};
`endif
    run_frame("postrst", 1'b0);
    check("postrst_addr", 32'(wr_addr), 32'd4);
    check("postrst_data", 32'(wr_data), 32'h99);

`ifdef FP_CMD_CHECKSUM_EN
    // 6: checksum good / bad
    frame_q = '{8'h12, 8'h3C, 8'h2E};
    run_frame("csum_ok", 1'b0);
    check("csum_ok_addr", 32'(wr_addr), 32'd2);
    check("csum_ok_data", 32'(wr_data), 32'h3C);
    frame_q = '{8'h12, 8'h3C, 8'h00};
    run_frame("csum_bad", 1'b0);
`endif

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      int sel;
      int len;
      logic [7:0] cmd;
      sel = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 5));
      cmd[3:0] = 4'($urandom_range(0, 15));
      case (sel)
        0: cmd[7:4] = 4'h0;
        1: cmd[7:4] = 4'h1;
        2: cmd[7:4] = 4'h2;
        default: cmd[7:4] = 4'($urandom_range(3, 15));
      endcase
      frame_q.delete();
      if (len > 0) frame_q.push_back(cmd);
      for (int i = 1; i < len; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      if (len >= 3 && $urandom_range(0, 1) == 1) frame_q[2] = frame_q[0] ^ frame_q[1];
      run_frame("rand", 1'b0);
    end

    check("no_double_pulse", 32'(dbl_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
